// File: rtl/prio_arb_enc_pkg.sv
// Shared encodings for the pending-request arbiter/encoder.
package prio_arb_enc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_arb_enc_pick.sv
// Combinational highest-set-bit finder; zero latency, no flow control.
module prio_pick #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan: the last hit is the highest index.
        for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
                idx = W'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_enc.sv
// Sticky request collector that serialises one index at a time onto valid/ready.
// Grant appears one cycle after pending is seen in IDLE; index held until accepted.
module prio_arb_enc
    import prio_arb_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         busy
);

    localparam logic [W:0]   N_EXT = (W+1)'(N);
    localparam logic [W-1:0] TOP   = W'(N - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_pending_nxt;
    logic [N-1:0]   w_clr_mask;
    logic [N-1:0]   w_pick_vec;
    logic [W-1:0]   r_out_idx;
    logic [W-1:0]   r_rr_ptr;
    logic [W-1:0]   w_shift;
    logic [W-1:0]   w_pick_raw;
    logic [W-1:0]   w_pick_idx;
    logic [W:0]     w_sum;
    logic           r_out_valid;
    logic           w_accept;
    logic           w_pick_any;

    // Rotate so that the bit at rr_ptr lands on the top position of the picker.
    always_comb begin
        w_shift = '0;
        if (mode == MODE_RR) begin
            w_shift = (r_rr_ptr == TOP) ? '0 : r_rr_ptr + W'(1);
        end
        w_pick_vec = N'({r_pending, r_pending} >> w_shift);
    end

    prio_pick #(.N(N)) u_pick (
        .vec (w_pick_vec),
        .idx (w_pick_raw),
        .any (w_pick_any)
    );

    // Un-rotate modulo N; one extra bit keeps non-power-of-2 sums from aliasing.
    always_comb begin
        w_sum = {1'b0, w_pick_raw} + {1'b0, w_shift};
        if (w_sum >= N_EXT) begin
            w_sum = w_sum - N_EXT;
        end
        w_pick_idx = w_sum[W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clr_mask  = '0;
        case (r_state)
            ST_IDLE: begin
                if (en && w_pick_any) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_accept    = 1'b1;
                    w_clr_mask  = N'(1) << r_out_idx;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_pending_nxt = (r_pending & ~w_clr_mask) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= TOP;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_HOLD) begin
                r_out_idx   <= w_pick_idx;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= (r_out_idx == '0) ? TOP : r_out_idx - W'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign pending   = r_pending;
    assign busy      = (|r_pending) || r_out_valid;

endmodule

// File: tb/tb_prio_arb_enc.sv
// Drives N=8, N=5 and N=16 arbiters in lockstep against a per-instance reference model.
module tb_prio_arb_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, mode, rdy;
    logic [31:0] req;

    logic        v8, v5, v16;
    logic        b8, b5, b16;
    logic [2:0]  i8, i5;
    logic [3:0]  i16;
    logic [7:0]  p8;
    logic [4:0]  p5;
    logic [15:0] p16;

    prio_arb_enc #(.N(8)) u_n8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req[7:0]),
        .out_valid(v8), .out_ready(rdy), .out_idx(i8), .pending(p8), .busy(b8));
    prio_arb_enc #(.N(5)) u_n5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req[4:0]),
        .out_valid(v5), .out_ready(rdy), .out_idx(i5), .pending(p5), .busy(b5));
    prio_arb_enc #(.N(16)) u_n16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req[15:0]),
        .out_valid(v16), .out_ready(rdy), .out_idx(i16), .pending(p16), .busy(b16));

    int total = 0;
    int bad   = 0;

    localparam int NI = 3;
    int          nn[NI] = '{8, 5, 16};
    logic [31:0] m_pend[NI];
    bit          m_vld[NI];
    int          m_idx[NI];
    int          m_rr[NI];
    int          q8[$];
    int          eq[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic dut_get(input int i, output int v, output int ix, output int p, output int b);
        case (i)
            0:       begin v = int'(v8);  ix = int'(i8);  p = int'(p8);  b = int'(b8);  end
            1:       begin v = int'(v5);  ix = int'(i5);  p = int'(p5);  b = int'(b5);  end
            default: begin v = int'(v16); ix = int'(i16); p = int'(p16); b = int'(b16); end
        endcase
    endtask

    // Reference pick: walk the priority order directly.
    function automatic int model_pick(input int i);
        int n = nn[i];
        if (!mode) begin
            for (int k = n - 1; k >= 0; k--)
                if (m_pend[i][k]) return k;
        end else begin
            for (int s = 0; s < n; s++) begin
                int k = (m_rr[i] - s + n) % n;
                if (m_pend[i][k]) return k;
            end
        end
        return 0;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            int          n = nn[i];
            logic [31:0] mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
            logic [31:0] np;
            bit          acc;
            if (rst) begin
                m_pend[i] = '0;
                m_vld[i]  = 1'b0;
                m_idx[i]  = 0;
                m_rr[i]   = n - 1;
            end else begin
                acc = m_vld[i] && rdy;
                np  = m_pend[i];
                if (acc) np[m_idx[i]] = 1'b0;
                np = np | (req & mask);
                if (!m_vld[i]) begin
                    if (en && m_pend[i] != 0) begin
                        m_idx[i] = model_pick(i);
                        m_vld[i] = 1'b1;
                    end
                end else if (acc) begin
                    m_vld[i] = 1'b0;
                    if (mode) m_rr[i] = (m_idx[i] == 0) ? n - 1 : m_idx[i] - 1;
                end
                m_pend[i] = np;
            end
        end
    endtask

    task automatic check_all();
        int v, ix, p, b;
        for (int i = 0; i < NI; i++) begin
            dut_get(i, v, ix, p, b);
            chk($sformatf("vld_n%0d", nn[i]), v, int'(m_vld[i]));
            chk($sformatf("idx_n%0d", nn[i]), ix, m_idx[i]);
            chk($sformatf("pend_n%0d", nn[i]), p, int'(m_pend[i]));
            chk($sformatf("busy_n%0d", nn[i]), b, int'((m_pend[i] != 0) || m_vld[i]));
        end
    endtask

    task automatic cyc(input bit r_rst, input bit r_en, input bit r_mode,
                       input bit r_rdy, input logic [31:0] r_req);
        rst  = r_rst;
        en   = r_en;
        mode = r_mode;
        rdy  = r_rdy;
        req  = r_req;
        if (v8 === 1'b1 && r_rdy && !r_rst) q8.push_back(int'(i8));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, q8.size(), eq.size());
        for (int k = 0; k < eq.size() && k < q8.size(); k++)
            chk($sformatf("%s_%0d", tag, k), q8[k], eq[k]);
    endtask

    task automatic do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        q8.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; rdy = 1'b0; req = '0;

        // Reset state, then fixed-priority drain of 5,2,1.
        do_reset();
        chk("rst_vld", int'(v8), 0);
        chk("rst_pend", int'(p8), 0);
        cyc(0, 1, 0, 1, 32'h26);
        repeat (8) cyc(0, 1, 0, 1, 0);
        eq = {5, 2, 1};
        check_q("t1_order");
        chk("t1_pend", int'(p8), 0);
        chk("t1_busy", int'(b8), 0);

        // Round-robin over all lines, wrapping back to the top.
        do_reset();
        cyc(0, 1, 1, 1, 32'hFFFF_FFFF);
        repeat (20) cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 32'hFFFF_FFFF);
        repeat (2) cyc(0, 1, 1, 1, 0);
        eq = {7, 6, 5, 4, 3, 2, 1, 0, 7};
        check_q("t2_rr");
        repeat (2) cyc(0, 1, 0, 1, 32'h80);
        q8.delete();
        repeat (10) cyc(0, 1, 0, 1, 32'h80);
        eq = {7, 7, 7, 7, 7};
        check_q("t2_fixed");

        // Held index survives backpressure and a higher request.
        do_reset();
        cyc(0, 1, 0, 0, 32'h08);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 0, 32'h80);
            chk("t3_hold_vld", int'(v8), 1);
            chk("t3_hold_idx", int'(i8), 3);
        end
        q8.delete();
        repeat (5) cyc(0, 1, 0, 1, 0);
        eq = {3, 7};
        check_q("t3_after");

        // Accept and re-request of the same bit in one cycle.
        do_reset();
        cyc(0, 1, 0, 0, 32'h04);
        cyc(0, 1, 0, 0, 0);
        q8.delete();
        cyc(0, 1, 0, 1, 32'h04);
        chk("t4_pend2", int'(p8[2]), 1);
        repeat (3) cyc(0, 1, 0, 1, 0);
        eq = {2, 2};
        check_q("t4_regrant");

        // Enable gating.
        do_reset();
        cyc(0, 0, 0, 0, 32'h11);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("t5_vld_off", int'(v8), 0);
        chk("t5_pend", int'(p8), 32'h11);
        cyc(0, 1, 0, 0, 0);
        chk("t5_vld_on", int'(v8), 1);
        chk("t5_idx", int'(i8), 4);

        // Reset during an outstanding grant, after the rr pointer has moved.
        do_reset();
        cyc(0, 1, 1, 0, 32'h40);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 32'h08);
        cyc(0, 1, 1, 0, 0);
        chk("t6_pre_vld", int'(v8), 1);
        cyc(1, 1, 1, 0, 0);
        chk("t6_vld", int'(v8), 0);
        chk("t6_idx", int'(i8), 0);
        chk("t6_pend", int'(p8), 0);
        chk("t6_busy", int'(b8), 0);
        q8.delete();
        cyc(0, 1, 1, 1, 32'hFF);
        repeat (3) cyc(0, 1, 1, 1, 0);
        eq = {7};
        check_q("t6_rrptr");

        // Randomised traffic across all three widths.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r = $urandom & $urandom;
            if ($urandom_range(0, 2) == 0) r = '0;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                (c % 200) >= 100 ? 1'b1 : ($urandom_range(0, 15) == 0),
                $urandom_range(0, 1) == 1, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
